// File: rtl/nibble_add_seq.sv
// nibble_add_seq: sequential wide adder that pushes one 4-bit slice per
// clock through a single shared full_adder4, least significant slice first,
// with the inter-slice carry held in a register. The wide result and carry
// out are published together on the completion edge only.

module full_adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
endmodule

module nibble_add_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   c_in,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   c_out
);
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Operands and accumulator held as arrays of nibbles so idx selects a slice directly
    logic [NIBBLES-1:0][3:0] a_reg;
    logic [NIBBLES-1:0][3:0] b_reg;
    logic [NIBBLES-1:0][3:0] acc;
    logic [NIBBLES-1:0][3:0] acc_next;
    logic                    carry_reg;
    logic [IW-1:0]           idx;

    logic [3:0] fa_sum;
    logic       fa_cout;
    logic       accept;
    logic       last;

    full_adder4 u_fa (
        .a     (a_reg[idx]),
        .b     (b_reg[idx]),
        .c_in  (carry_reg),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (idx == LAST);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // Accumulator with the current slice merged in; also the completed result on the last slice
    always_comb begin
        acc_next      = acc;
        acc_next[idx] = fa_sum;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start is only honoured in IDLE or DONE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, per-slice accumulation and atomic result publish
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= c_in;
            idx       <= '0;
        end else if (state == RUN) begin
            acc       <= acc_next;
            carry_reg <= fa_cout;
            if (last) begin
                sum   <= acc_next;
                c_out <= fa_cout;
            end else begin
                idx   <= idx + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_nibble_add_seq.sv
// Bench for nibble_add_seq: a 4-nibble and a 1-nibble instance on one clock.
// Expected results are queued when an operation is issued and retired when done pulses.

module tb_nibble_add_seq;
    logic        clk = 1'b0;
    logic        rst;

    logic        start;
    logic [15:0] a, b;
    logic        c_in;
    logic        busy, done, c_out;
    logic [15:0] sum;

    logic        start1;
    logic [3:0]  a1, b1;
    logic        c1_in;
    logic        busy1, done1, c1_out;
    logic [3:0]  sum1;

    logic [16:0] exp_q[$];
    logic [4:0]  exp1_q[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nibble_add_seq #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out)
    );

    nibble_add_seq #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c_in(c1_in),
        .busy(busy1), .done(done1), .sum(sum1), .c_out(c1_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard retire for the 4-nibble instance, plus mutual exclusion of busy/done
    always @(negedge clk) begin
        if (!rst) begin
            check("busy_done_excl", 64'(busy && done), 64'd0);
            check("busy_done_excl1", 64'(busy1 && done1), 64'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    check("result", 64'({c_out, sum}), 64'(e));
                end
            end
            if (done1) begin
                if (exp1_q.size() == 0) begin
                    check("unexpected_done1", 64'd1, 64'd0);
                end else begin
                    logic [4:0] e1;
                    e1 = exp1_q.pop_front();
                    check("result1", 64'({c1_out, sum1}), 64'(e1));
                end
            end
        end
    end

    // Issue an operation at the next falling edge; returns #1 after the accepting edge
    task automatic issue(input logic [15:0] aa, input logic [15:0] bb, input logic ci);
        @(negedge clk);
        a = aa; b = bb; c_in = ci; start = 1'b1;
        exp_q.push_back({1'b0, aa} + {1'b0, bb} + {16'd0, ci});
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: plain, 1: zero operand ports during RUN, 2: start pulse in second RUN cycle
    // Returns #1 after the completion edge with done checked high
    task automatic op4(input logic [15:0] aa, input logic [15:0] bb, input logic ci, input int mode);
        issue(aa, bb, ci);
        for (int i = 0; i < 4; i++) begin
            check("busy_run", 64'(busy), 64'd1);
            check("done_run", 64'(done), 64'd0);
            if (mode == 1 && i == 1) begin a = '0; b = '0; end
            if (mode == 2 && i == 1) begin start = 1'b1; a = 16'h0F0F; b = 16'h0F0F; c_in = 1'b1; end
            if (mode == 2 && i == 2) start = 1'b0;
            @(posedge clk); #1;
        end
        check("done_pulse", 64'(done), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
    endtask

    task automatic op1(input logic [3:0] aa, input logic [3:0] bb, input logic ci);
        @(negedge clk);
        a1 = aa; b1 = bb; c1_in = ci; start1 = 1'b1;
        exp1_q.push_back({1'b0, aa} + {1'b0, bb} + {4'd0, ci});
        @(posedge clk); #1;
        start1 = 1'b0;
        check("busy1", 64'(busy1), 64'd1);
        check("done1_low", 64'(done1), 64'd0);
        @(posedge clk); #1;
        check("done1", 64'(done1), 64'd1);
        check("busy1_low", 64'(busy1), 64'd0);
        @(posedge clk); #1;
        check("done1_fall", 64'(done1), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; c1_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(c_out), 64'd0);
        check("rst_out1", 64'({busy1, done1, c1_out, sum1}), 64'd0);
        @(negedge clk); rst = 1'b0;

        // Full carry ripple across all nibbles
        op4(16'hFFFF, 16'h0001, 1'b0, 0);
        @(posedge clk); #1;
        check("done_fall", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("hold_sum", 64'({c_out, sum}), 64'h10000);

        // Operand ports change after acceptance
        op4(16'h1234, 16'h4321, 1'b1, 1);
        @(posedge clk); #1;

        // Start during RUN is ignored
        op4(16'hABCD, 16'h1111, 1'b0, 2);
        @(posedge clk); #1;
        check("no_restart", 64'(busy), 64'd0);

        // Asynchronous reset mid-RUN
        issue(16'h7777, 16'h2222, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_sum", 64'(sum), 64'd0);
        check("abort_cout", 64'(c_out), 64'd0);
        exp_q.delete();
        @(negedge clk); rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done), 64'd0);
        op4(16'h0F0F, 16'hF0F0, 1'b1, 0);

        // Back-to-back: start held through DONE accepts the next operation
        @(posedge clk); #1;
        op4(16'h1234, 16'h0001, 1'b0, 0);
        a = 16'h8000; b = 16'h8000; c_in = 1'b0; start = 1'b1;
        exp_q.push_back(17'h10000);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("b2b_busy", 64'(busy), 64'd1);
            check("b2b_hold", 64'({c_out, sum}), 64'h01235);
            @(posedge clk); #1;
        end
        check("b2b_done", 64'(done), 64'd1);
        @(posedge clk); #1;

        // Single-nibble instance
        op1(4'b1111, 4'b1111, 1'b1);
        op1(4'b1000, 4'b0001, 1'b1);
        op1(4'b0101, 4'b0011, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        check("sb_drain1", 64'(exp1_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Multi-cycle sequencer that adds two NIBBLES×4-bit operands through a single shared full_adder4 instance, processing one nibble per clock from least to most significant with a registered ripple carry. It sits between a requester issuing start/operand pulses and the 4-bit adder datapath. It owns the adder's inputs and the inter-nibble carry, and presents an atomic wide result with a done pulse.

## Interface
- NIBBLES, 4, number of 4-bit slices per operand; legal range 1..16; operand width W = 4*NIBBLES
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on rising edge, accepted only in IDLE or DONE
- a  input  W  operand A, sampled on the accepting edge only
- b  input  W  operand B, sampled on the accepting edge only
- c_in  input  1  carry into nibble 0, sampled on the accepting edge only
- busy  output  1  high while in RUN
- done  output  1  single-cycle pulse, high while in DONE
- sum  output  W  registered result, updated atomically at completion, held otherwise
- c_out  output  1  registered carry out of the top nibble, updated with sum

## Operation
- One full_adder4 instance inside the block. Its inputs are a_reg[idx], b_reg[idx] and carry_reg. Its outputs feed the partial accumulator and next carry.
- FSM states and transitions:
  - IDLE -> RUN on start=1: latch a, b and c_in into a_reg, b_reg and carry_reg; set idx=0.
  - IDLE with start=0: stay in IDLE.
  - RUN, each edge: write the adder sum into acc[idx]; carry_reg <= adder c_out; idx <= idx+1.
  - RUN on the edge that processes idx = NIBBLES-1: load sum <= completed acc and c_out <= adder c_out; go to DONE.
  - DONE, next edge with start=1: behave exactly as the IDLE acceptance (back-to-back operation), go to RUN.
  - DONE, next edge with start=0: go to IDLE.
- start while in RUN: ignored, with no effect on operands, idx or the result.
- Operand ports may change freely after the accepting edge; only the latched copies are used.
- sum and c_out never show partial values. They change only on the completion edge; reset also clears them.
- Arithmetic: {c_out, sum} = a + b + c_in, computed modulo 2^(W+1), with no overflow flag.
- idx width is ceil(log2(NIBBLES)) bits, minimum 1. idx never exceeds NIBBLES-1.

## Timing
- Reset value of every output: busy=0, done=0, sum=0, c_out=0. Internal reset values: state=IDLE, idx=0, carry_reg=0, acc=0.
- Reset is asynchronous. Asserting rst mid-RUN aborts immediately: no done pulse, and sum and c_out are cleared to 0.
- Start accepted at edge k:
  - busy is high from after edge k until edge k+NIBBLES.
  - sum and c_out are valid after edge k+NIBBLES.
  - done is high for exactly the one cycle after edge k+NIBBLES.
- Latency: NIBBLES+1 edges from the accepting edge to done falling, when there is no back-to-back start.
- Throughput: one operation per NIBBLES+1 cycles at most. A new start is accepted on the edge that ends DONE.
- For NIBBLES=1: busy for 1 cycle, then done. The path is identical with idx fixed at 0.
- done and busy are never high in the same cycle.

## Test plan
- NIBBLES=4; a=16'hFFFF, b=16'h0001, c_in=0; start pulsed at edge k -> busy high for 4 cycles, done high 1 cycle after edge k+4, sum=16'h0000, c_out=1.
- a=16'h1234, b=16'h4321, c_in=1 -> sum=16'h5556, c_out=0. Drive a and b to 16'h0000 one cycle after the accepting edge -> result unaffected.
- During the second RUN cycle of an operation, pulse start with a=16'h0F0F -> ignored; the original result and done timing are unchanged.
- Assert rst asynchronously mid-RUN (between edges k+2 and k+3) -> busy, done, sum and c_out all 0 immediately; no done pulse follows; the next start completes normally.
- Back-to-back: hold start=1 through DONE with a=16'h8000, b=16'h8000, c_in=0 -> second operation accepted on the edge ending DONE, result sum=16'h0000, c_out=1. The first result holds until the second completes.
- NIBBLES=1; a=4'b1111, b=4'b1111, c_in=1 -> sum=4'b1111, c_out=1, with done 1 cycle after busy. Also a=4'b1000, b=4'b0001, c_in=1 -> sum=4'b1010, c_out=0.
